// File: rtl/pipe_intc_pkg.sv
// Shared definitions for the interrupt controller / CP0 block:
// FSM encoding, CP0 register numbers, PC-mux codes and register bit positions.
package pipe_intc_pkg;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_t;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [1:0] SELPC_NORMAL = 2'b00;
    localparam logic [1:0] SELPC_EPC    = 2'b01;
    localparam logic [1:0] SELPC_VEC    = 2'b10;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_IP   = 8;
    localparam int CAUSE_BD   = 31;

    localparam logic [31:0] DEFAULT_VECTOR = 32'h0000_0008;

    // Status image: only IE and EXL are implemented, the rest reads zero.
    function automatic logic [31:0] pack_status(input logic ie, input logic exl);
        logic [31:0] v;
        v = '0;
        v[STATUS_IE]  = ie;
        v[STATUS_EXL] = exl;
        return v;
    endfunction

    // Cause image: BD and IP only; ExcCode is always 0 (interrupt).
    function automatic logic [31:0] pack_cause(input logic bd, input logic ip);
        logic [31:0] v;
        v = '0;
        v[CAUSE_BD] = bd;
        v[CAUSE_IP] = ip;
        return v;
    endfunction

endpackage

// File: rtl/pipe_intc_if.sv
// Pipeline-side bus of the interrupt controller: ID-stage decode inputs,
// PC-mux steering outputs and the CP0 register views.
interface pipe_intc_if;
    logic        nostall;
    logic [31:0] id_pc;
    logic [31:0] ex_pc;
    logic        id_bd;
    logic        id_eret;
    logic        id_mtc0;
    logic [4:0]  id_rd;
    logic [31:0] wdata;
    logic [31:0] cp0_rdata;
    logic [1:0]  selpc;
    logic [31:0] vec_pc;
    logic        cancel;
    logic        inta;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    // CPU pipeline side
    modport master (
        output nostall, id_pc, ex_pc, id_bd, id_eret, id_mtc0, id_rd, wdata,
        input  cp0_rdata, selpc, vec_pc, cancel, inta, status, cause, epc
    );

    // Interrupt controller side
    modport slave (
        input  nostall, id_pc, ex_pc, id_bd, id_eret, id_mtc0, id_rd, wdata,
        output cp0_rdata, selpc, vec_pc, cancel, inta, status, cause, epc
    );
endinterface

// File: rtl/pipe_intc_sync2.sv
// Two-flop synchroniser for a level signal that is asynchronous to clk.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_reg;
    logic s2_reg;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= d;
            s2_reg <= s1_reg;
        end
    end

    assign q = s2_reg;
endmodule

// File: rtl/pipe_intc.sv
// Interrupt controller and CP0 (Status/Cause/EPC) for the five-stage CPU.
// Decides interrupt takes in ID, handles eret/mtc0/mfc0 and steers the PC mux.
module pipe_intc
    import pipe_intc_pkg::*;
#(
    parameter logic [31:0] VECTOR = DEFAULT_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        intr,
    pipe_intc_if.slave  bus
);
    state_t      state_reg;
    logic        ie_reg;
    logic        exl_reg;
    logic        bd_reg;
    logic [31:0] epc_reg;
    logic        ip_sync;

    logic        take;
    logic        do_eret;
    logic        do_mtc0;

    sync2 u_sync_intr (
        .clk (clk),
        .rst (rst),
        .d   (intr),
        .q   (ip_sync)
    );

    // Decision logic: take beats eret beats mtc0, and nothing acts while stalled.
    always_comb begin
        take    = (state_reg == ST_RUN) && ip_sync && ie_reg && !exl_reg && bus.nostall;
        do_eret = bus.id_eret && bus.nostall && !take;
        do_mtc0 = bus.id_mtc0 && bus.nostall && !take && !do_eret;
    end

    // FSM and CP0 register updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            ie_reg    <= 1'b0;
            exl_reg   <= 1'b0;
            bd_reg    <= 1'b0;
            epc_reg   <= '0;
        end else if (take) begin
            // A slot instruction must restart at its branch so the branch re-executes.
            epc_reg   <= bus.id_bd ? bus.ex_pc : bus.id_pc;
            bd_reg    <= bus.id_bd;
            ie_reg    <= 1'b0;
            exl_reg   <= 1'b1;
            state_reg <= ST_ISR;
        end else if (do_eret) begin
            ie_reg    <= 1'b1;
            exl_reg   <= 1'b0;
            bd_reg    <= 1'b0;
            state_reg <= ST_RUN;
        end else if (do_mtc0) begin
            case (bus.id_rd)
                CP0_STATUS: begin
                    ie_reg  <= bus.wdata[STATUS_IE];
                    exl_reg <= bus.wdata[STATUS_EXL];
                end
                CP0_EPC:    epc_reg <= bus.wdata;
                default:    ; // Cause is read-only; unmapped numbers ignored
            endcase
        end
    end

    // PC-mux steering and ID squash, valid only in the decision cycle.
    always_comb begin
        bus.selpc  = SELPC_NORMAL;
        bus.cancel = 1'b0;
        bus.inta   = 1'b0;
        if (take) begin
            bus.selpc  = SELPC_VEC;
            bus.cancel = 1'b1;
            bus.inta   = 1'b1;
        end else if (do_eret) begin
            bus.selpc  = SELPC_EPC;
            bus.cancel = 1'b1;
        end
    end

    // Register views and mfc0 read port (no same-cycle mtc0 bypass).
    always_comb begin
        bus.status = pack_status(ie_reg, exl_reg);
        bus.cause  = pack_cause(bd_reg, ip_sync);
        bus.epc    = epc_reg;
        bus.vec_pc = VECTOR;
        case (bus.id_rd)
            CP0_STATUS: bus.cp0_rdata = bus.status;
            CP0_CAUSE:  bus.cp0_rdata = bus.cause;
            CP0_EPC:    bus.cp0_rdata = bus.epc;
            default:    bus.cp0_rdata = '0;
        endcase
    end

endmodule

// File: doc/pipe_intc.md
# pipe_intc

Interrupt controller and CP0 register block for the five-stage pipelined CPU. It synchronises the external interrupt line and decides, in ID, when an interrupt is taken. On a take it cancels the ID instruction, saves the return PC (with branch-delay-slot correction) and steers the PC mux to the handler vector. It also executes `eret`, `mtc0` and `mfc0` for the Status, Cause and EPC registers.

## Interface
Parameters:
- `VECTOR`, default 32'h0000_0008: handler entry address driven on `vec_pc`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `intr` in 1: external interrupt request, level, asynchronous to `clk`.
- `nostall` in 1: from the ID control unit; no take, `eret` or `mtc0` acts while it is 0.
- `id_pc` in 32: PC of the ID instruction.
- `ex_pc` in 32: PC of the EXE instruction.
- `id_bd` in 1: the ID instruction sits in a branch delay slot (branch or jump in EXE).
- `id_eret` in 1: decoded `eret` in ID.
- `id_mtc0` in 1: decoded `mtc0` in ID.
- `id_rd` in 5: CP0 register number (12 = Status, 13 = Cause, 14 = EPC).
- `wdata` in 32: `mtc0` write data (forwarded rt value).
- `cp0_rdata` out 32: `mfc0` read data, combinational on `id_rd`; 0 for unmapped numbers.
- `selpc` out 2: 00 = normal, 01 = EPC, 10 = `vec_pc`.
- `vec_pc` out 32: constant `VECTOR`.
- `cancel` out 1: turn the ID instruction into a NOP entering EXE.
- `inta` out 1: one-cycle acknowledge on a take.
- `status`, `cause`, `epc` out 32 each: register contents.

## Operation
- Synchroniser: `intr` → s1 → s2, two flops. `cause[8]` (IP) mirrors s2 every cycle.
- Status: bit0 IE, bit1 EXL; all other bits read 0.
- Cause: bit31 BD, bit8 IP, bits[6:2] ExcCode (always 0 = interrupt); all other bits 0.
- States:
  - RUN: `take` = s2 & IE & ~EXL & `nostall`.
  - When `take` = 1 in that cycle:
    - `selpc` = 10, `cancel` = 1, `inta` = 1.
    - On the edge: EPC ← `id_bd` ? `ex_pc` : `id_pc`; BD ← `id_bd`; IE ← 0; EXL ← 1; go to ISR.
  - ISR: `intr` is ignored.
  - `eret` in any state with `nostall` = 1 and no take:
    - `selpc` = 01, `cancel` = 1 (squashes the fetched slot instruction).
    - On the edge: IE ← 1, EXL ← 0, BD ← 0; go to RUN.
- `mtc0` with `nostall` = 1 and no take in the same cycle writes the addressed register on the edge.
  - Status: only bits[1:0] are written.
  - Cause: read-only, write ignored.
  - EPC: all 32 bits.
- Priority within one cycle: take > `eret` > `mtc0`. A cancelled `eret` or `mtc0` has no effect and is re-executed after the handler returns.
- `mfc0` reads current register values. The same-cycle `mtc0` value is not bypassed; the pipeline guarantees separation.

## Timing
- Reset values: state RUN; Status = Cause = EPC = 0; s1 = s2 = 0; `selpc` = 00; `cancel` = `inta` = 0.
- Reset mid-handler returns to RUN with IE = 0.
- Latency: `intr` high before edge k gives s2 = 1 after edge k+1. The earliest take is the cycle after edge k+1.
- A take is held off while `nostall` = 0 and occurs in the first cycle with `nostall` = 1.
- `mtc0` setting IE takes effect for the take decision in the cycle after its write edge. `mtc0` clearing IE in the cycle of a pending take loses to the take.
- `intr` dropping before s2 samples it produces no take. `intr` held through the handler re-takes in the first RUN cycle after `eret`.
- `selpc`, `cancel` and `inta` are combinational from state and inputs, each valid for exactly the decision cycle.

## Structure
- Shared package holds:
  - state encoding (RUN, ISR);
  - CP0 register numbers 12/13/14;
  - `selpc` codes 00/01/10;
  - Status and Cause bit positions;
  - default `VECTOR`.
- One sub-module, `sync2`: a two-flop synchroniser with asynchronous active-high reset, reused for `intr`.

## Test plan
- Reset, then `mtc0` Status = 1 with `intr` = 0 → IE = 1; no `inta` for 10 cycles; `selpc` = 00.
- IE = 1, `id_pc` = 0x40, `id_bd` = 0; raise `intr` before edge k → `inta` = `cancel` = 1 and `selpc` = 10 in the cycle after edge k+1; afterwards EPC = 0x40, IE = 0, EXL = 1, state ISR.
- Same as above but `id_bd` = 1 and `ex_pc` = 0x3C → EPC = 0x3C, `cause[31]` = 1.
- Pending take with `nostall` = 0 for 3 cycles → no `inta`; take occurs on the first cycle with `nostall` = 1.
- In ISR, `eret` with `intr` still high → `selpc` = 01, `cancel` = 1; IE = 1 next cycle; re-take in the following RUN cycle with the new EPC.
- `mtc0` EPC = 0x1234 in the same cycle as a take → EPC = the interrupt return PC, not 0x1234; `mfc0` of `id_rd` = 13 returns BD/IP state with ExcCode = 0.
